// File: rtl/c17_bist_pkg.sv
//------------------------------------------------------------------------------
// Module   : c17_bist_pkg
// Purpose  : Shared widths, FSM encoding and LFSR/MISR step functions for the
//            c17 self-test harness.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package c17_bist_pkg;

  localparam int LFSR_W      = 5;
  localparam int MISR_W      = 16;
  localparam int CNT_W       = 5;
  localparam int LFSR_TAP_HI = 4;
  localparam int LFSR_TAP_LO = 2;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // x^5 + x^3 + 1, shifting towards the MSB
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] cur,
                                                  input logic [1:0]        resp);
    return {cur[MISR_W-2:0], 1'b0}
         ^ (cur[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
         ^ {{(MISR_W-2){1'b0}}, resp};
  endfunction

endpackage

`default_nettype wire

// File: rtl/c17_bist_misr.sv
//------------------------------------------------------------------------------
// Module   : c17_bist_misr
// Purpose  : 16-bit multiple-input signature register compacting the two c17
//            responses; load has priority over enable.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module c17_bist_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [MISR_W-1:0] seed_i,
  input  logic [1:0]        data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = seed_i;
    end else if (en_i) begin
      sig_d = misr_step(sig_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed_i;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

`default_nettype wire

// File: rtl/c17_bist_driver.sv
//------------------------------------------------------------------------------
// Module   : c17_bist_driver
// Purpose  : LFSR stimulus / MISR compaction harness around the c17 netlist.
//            Optional golden compare enabled by defining C17_BIST_CMP_EN.
//            Legal ranges: PAT_COUNT 1..31, RESP_LAT 1..4, LFSR_SEED != 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module c17_bist_driver
  import c17_bist_pkg::*;
#(
  parameter int unsigned       PAT_COUNT  = 31,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 5'b00001,
  parameter logic [MISR_W-1:0] MISR_SEED  = 16'hFFFF,
  parameter int unsigned       RESP_LAT   = 1
`ifdef C17_BIST_CMP_EN
  ,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              nx1,
  output logic              nx2,
  output logic              nx3,
  output logic              nx6,
  output logic              nx7,
  input  logic              nx22,
  input  logic              nx23,
`ifdef C17_BIST_CMP_EN
  output logic              pass,
`endif
  output logic [MISR_W-1:0] sig
);

  localparam logic [CNT_W-1:0] c_pat_last = CNT_W'(PAT_COUNT - 1);

  state_e              state_q;
  state_e              state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_d;
  logic [LFSR_W-1:0]   stim_q;
  logic [LFSR_W-1:0]   stim_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [RESP_LAT-1:0] vpipe_q;
  logic                launch;
  logic                capture;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        lfsr_d  = LFSR_SEED;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        stim_d = lfsr_q;
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == c_pat_last) state_d = DRAIN;
      end
      // Leave only once every tagged launch has been captured.
      DRAIN: begin
        if (vpipe_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      stim_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
    end
  end

  assign launch  = (state_q == RUN);
  assign capture = vpipe_q[RESP_LAT-1];

  generate
    if (RESP_LAT == 1) begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (rst) vpipe_q <= '0;
        else     vpipe_q <= launch;
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (rst) vpipe_q <= '0;
        else     vpipe_q <= {vpipe_q[RESP_LAT-2:0], launch};
      end
    end
  endgenerate

  c17_bist_misr u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == LOAD),
    .en_i   (capture),
    .seed_i (MISR_SEED),
    .data_i ({nx23, nx22}),
    .sig_o  (sig)
  );

`ifdef C17_BIST_CMP_EN
  logic pass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      pass_q <= 1'b0;
    end else if (state_q == DONE) begin
      pass_q <= (sig == GOLDEN_SIG);
    end
  end

  assign pass = pass_q;
`endif

  assign {nx7, nx6, nx3, nx2, nx1} = stim_q;
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_c17_bist_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_c17_bist_driver
// Purpose  : Self-checking bench for c17_bist_driver (three configurations,
//            c17 model with per-pattern response corruption masks).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_c17_bist_driver;

  localparam int N_DUT = 3;

  function automatic int pc_of(input int g);
    case (g)
      0:       return 1;
      1:       return 5;
      default: return 31;
    endcase
  endfunction

  function automatic int rl_of(input int g);
    case (g)
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // c17 netlist; s = {nx7,nx6,nx3,nx2,nx1}, result = {nx23,nx22}
  function automatic logic [1:0] c17_f(input logic [4:0] s);
    logic n10, n11, n16, n19;
    n10 = ~(s[0] & s[2]);
    n11 = ~(s[2] & s[3]);
    n16 = ~(s[1] & n11);
    n19 = ~(n11 & s[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  // Signature as polynomial arithmetic: multiply by x, reduce mod 0x11021, add response.
  function automatic logic [15:0] sig_f(input logic [15:0] cur, input logic [1:0] d);
    logic [16:0] t;
    t = {cur, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {14'd0, d};
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [N_DUT];
  logic [1:0] mask [N_DUT][32];
  logic [4:0] last_stim [N_DUT];
  wire        busy_w [N_DUT];
  wire        done_w [N_DUT];
  wire [4:0]  stim_w [N_DUT];
  wire [15:0] sig_w [N_DUT];
`ifdef C17_BIST_CMP_EN
  wire        pass_w [N_DUT];
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    wire       n1, n2, n3, n6, n7;
    logic [1:0] resp_now, rp0, rp1, rp2, resp_use;

    assign stim_w[g] = {n7, n6, n3, n2, n1};
    assign resp_now  = c17_f(stim_w[g]) ^ mask[g][stim_w[g]];

    // Response delay line so the captured value belongs to the pattern launched RESP_LAT cycles earlier.
    always_ff @(posedge clk) begin
      rp0 <= resp_now;
      rp1 <= rp0;
      rp2 <= rp1;
    end
    assign resp_use = (rl_of(g) == 1) ? resp_now :
                      (rl_of(g) == 2) ? rp0 :
                      (rl_of(g) == 3) ? rp1 : rp2;

    c17_bist_driver #(
      .PAT_COUNT  (pc_of(g)),
      .RESP_LAT   (rl_of(g))
`ifdef C17_BIST_CMP_EN
      , .GOLDEN_SIG (16'hEFDF)
`endif
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[g]),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .nx1   (n1),
      .nx2   (n2),
      .nx3   (n3),
      .nx6   (n6),
      .nx7   (n7),
      .nx22  (resp_use[0]),
      .nx23  (resp_use[1]),
`ifdef C17_BIST_CMP_EN
      .pass  (pass_w[g]),
`endif
      .sig   (sig_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int idx, input string tag);
    check_eq($sformatf("%s d%0d busy", tag, idx), busy_w[idx], 1'b0);
    check_eq($sformatf("%s d%0d done", tag, idx), done_w[idx], 1'b0);
    check_eq($sformatf("%s d%0d sig", tag, idx), sig_w[idx], 16'hFFFF);
    check_eq($sformatf("%s d%0d stim", tag, idx), stim_w[idx], 5'b00000);
`ifdef C17_BIST_CMP_EN
    check_eq($sformatf("%s d%0d pass", tag, idx), pass_w[idx], 1'b0);
`endif
  endtask

  // One run; mid_start pulses start before edge T+mid_start, abort_at asserts rst before edge T+abort_at.
  task automatic run_one(input int idx, input int mid_start, input int abort_at);
    int          p, r;
    logic [4:0]  seq [$];
    logic [4:0]  s;
    logic [4:0]  exp_stim;
    logic [15:0] exp_sig;
    logic [31:0] seen;
    p = pc_of(idx);
    r = rl_of(idx);
    s = 5'b00001;
    exp_sig = 16'hFFFF;
    seen = '0;
    for (int k = 0; k < p; k++) begin
      seq.push_back(s);
      exp_sig = sig_f(exp_sig, c17_f(s) ^ mask[idx][s]);
      s = {s[3:0], s[4] ^ s[2]};
    end

    @(negedge clk); start[idx] = 1'b1;
    @(negedge clk); start[idx] = 1'b0;
    for (int c = 1; c <= 5 + p + r; c++) begin
      if (c == abort_at) begin
        start[idx] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
          check_idle(idx, $sformatf("abort c%0d+%0d", c, j));
          @(negedge clk);
        end
        for (int i = 0; i < N_DUT; i++) last_stim[i] = 5'b00000;
        return;
      end
      start[idx] = (c == mid_start);
      @(negedge clk);
      check_eq($sformatf("d%0d c%0d busy", idx, c), busy_w[idx], (c >= 1) && (c <= 1 + p + r));
      check_eq($sformatf("d%0d c%0d done", idx, c), done_w[idx], c == 2 + p + r);
      if (c < 2)          exp_stim = last_stim[idx];
      else if (c - 2 < p) exp_stim = seq[c-2];
      else                exp_stim = seq[p-1];
      check_eq($sformatf("d%0d c%0d stim", idx, c), stim_w[idx], exp_stim);
      if (c >= 2 && c <= 1 + p) seen[stim_w[idx]] = 1'b1;
      if (c == 1)
        check_eq($sformatf("d%0d c%0d sig_seed", idx, c), sig_w[idx], 16'hFFFF);
      if (c >= 2 + p + r)
        check_eq($sformatf("d%0d c%0d sig", idx, c), sig_w[idx], exp_sig);
`ifdef C17_BIST_CMP_EN
      check_eq($sformatf("d%0d c%0d pass", idx, c), pass_w[idx],
               (c >= 3 + p + r) ? (exp_sig == 16'hEFDF) : 1'b0);
`endif
    end
    start[idx] = 1'b0;
    check_eq($sformatf("d%0d distinct_stim", idx), $countones(seen), p);
    last_stim[idx] = seq[p-1];
  endtask

  initial begin
    int idx;
    for (int i = 0; i < N_DUT; i++) begin
      start[i] = 1'b0;
      last_stim[i] = 5'b00000;
      for (int v = 0; v < 32; v++) mask[i][v] = 2'b00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) check_idle(i, "in_reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) check_idle(i, "post_reset");
    end

    run_one(0, 0, 0);
    check_eq("p1_clean_sig", sig_w[0], 16'hEFDF);
    mask[0][1] = 2'b11;
    run_one(0, 0, 0);
    check_eq("p1_forced_sig", sig_w[0], 16'hEFDC);
    mask[0][1] = 2'b01;
    run_one(0, 0, 0);
    mask[0][1] = 2'b00;

    run_one(1, 0, 0);
    run_one(1, 3 + 5 + 3, 0);
    run_one(2, 12, 0);

    repeat (6) begin
      idx = $urandom_range(0, N_DUT - 1);
      for (int v = 0; v < 32; v++) mask[idx][v] = 2'($urandom);
      run_one(idx, 0, 0);
    end

    run_one(2, 0, 12);
    for (int v = 0; v < 32; v++) mask[0][v] = 2'b00;
    run_one(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/c17_bist_driver.md
# c17_bist_driver

Self-test harness stage that wraps the c17_slack combinational netlist. It drives the five c17 primary inputs from a registered 5-bit maximal-length LFSR and compacts the two c17 primary outputs into a 16-bit MISR signature. A start/busy/done handshake sequences the run. The block gives the timing flow a clocked launch/capture path around c17, with flop-to-flop paths through the netlist.

## Interface

Parameters:
- PAT_COUNT, 31: patterns applied per run; legal range 1..31.
- LFSR_SEED, 5'b00001: LFSR load value at start; must be non-zero.
- MISR_SEED, 16'hFFFF: MISR load value at start.
- RESP_LAT, 1: cycles from stimulus launch to response capture; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle run request.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; sig is final in this cycle.
- nx1, nx2, nx3, nx6, nx7  out  1 each  registered stimulus to the c17 PIs (same names as the c17 ports).
- nx22, nx23  in  1 each  c17 responses.
- sig  out  16  MISR signature; held from done until the next accepted start.

## Operation

- Stimulus bit map from LFSR state q[4:0]: nx1=q[0], nx2=q[1], nx3=q[2], nx6=q[3], nx7=q[4].
- LFSR update: q <= {q[3:0], q[4]^q[2]} (x^5+x^3+1, period 31).
- MISR update on each capture: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {14'b0, nx23, nx22}.
- FSM states:
  - IDLE: start accepted → LOAD.
  - LOAD: q=LFSR_SEED, sig=MISR_SEED, pattern counter cleared; → RUN.
  - RUN: one pattern launched per cycle, counter increments; after PAT_COUNT launches → DRAIN.
  - DRAIN: waits for the remaining captures (RESP_LAT cycles); → DONE.
  - DONE: done=1 for one cycle; → IDLE.
- Capture alignment: a RESP_LAT-deep valid shift register tags each launch. The MISR updates only when the tagged bit emerges. Exactly PAT_COUNT captures occur per run.
- start is ignored in LOAD/RUN/DRAIN/DONE. No queuing.
- When no run is active, stimulus holds its last value.

## Timing

- Reset values: busy=0, done=0, sig=MISR_SEED, all nx* outputs 0, LFSR=LFSR_SEED, FSM=IDLE, valid pipe cleared.
- rst mid-run aborts immediately to the reset state. No done is issued.
- Latency: start accepted at edge T → busy=1 after T+1. The first pattern is driven after T+2. done asserts after T+2+PAT_COUNT+RESP_LAT, with busy dropping in the same cycle.
- start in the same cycle as done: ignored (FSM not yet IDLE).
- Counter is 5 bits wide. The PAT_COUNT=31 run reaches the terminal count without wrapping. The LFSR visits each non-zero state once.

## Configuration

- C17_BIST_CMP_EN defined:
  - Adds parameter GOLDEN_SIG (default 16'h0000) and output `pass` (1 bit).
  - `pass` is registered on done as (sig_final == GOLDEN_SIG) and held until the next accepted start.
  - `pass` resets to 0.
- C17_BIST_CMP_EN not defined: neither the parameter nor the port exists, and there is no compare logic.

## Structure

- Package c17_bist_pkg holds:
  - the FSM state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - constants LFSR_W=5, MISR_W=16, MISR_POLY=16'h1021, LFSR_TAP_HI=4, LFSR_TAP_LO=2.
- Sub-module c17_bist_misr: MISR register with load/enable/seed inputs. The top level holds the FSM, LFSR, counter and valid pipe.

## Test plan

- Reset, no start: sig=16'hFFFF, busy=0, {nx7,nx6,nx3,nx2,nx1}=5'b00000 indefinitely.
- Start with PAT_COUNT=1, c17 attached, default seeds:
  - the first stimulus is 5'b00001, c17 returns nx22=0 and nx23=0;
  - done asserts 4 cycles after start; sig=16'hEFDF.
- Start with PAT_COUNT=1 and the response forced to nx22=1, nx23=1 → sig=16'hEFDC.
- Start with PAT_COUNT=5 and default seed: the stimulus sequence is 00001, 00010, 00100, 01001, 10010. There are exactly 5 MISR updates, and done follows after RESP_LAT cycles.
- Full run with PAT_COUNT=31:
  - all 31 non-zero stimuli occur once;
  - a start pulsed mid-run is ignored;
  - rst asserted at pattern 10 → all outputs return to reset values with no done.
- With C17_BIST_CMP_EN: GOLDEN_SIG=16'hEFDF and PAT_COUNT=1 → pass=1 after done. Injecting nx22=1 gives pass=0.
